// File: rtl/config_reg_bank_if.sv
// GPIO write bus and committed-register outputs of config_reg_bank.
// The PS side drives gpio_in; the register bank drives everything else.
interface config_reg_bank_if #(
    parameter int word_width = 8,
    parameter int num_words  = 4,
    parameter int num_regs   = 4
);
    logic [31:0]                                gpio_in;
    logic [num_regs*num_words*word_width-1:0]   reg_out;
    logic [num_regs-1:0]                        reg_complete;
    logic                                       commit_pulse;
    logic                                       err_partial;

    modport master (output gpio_in, input reg_out, reg_complete, commit_pulse, err_partial);
    modport slave  (input gpio_in, output reg_out, reg_complete, commit_pulse, err_partial);
endinterface

// File: rtl/config_reg_bank.sv
// Double-buffered configuration register bank fed by the PS GPIO write bus.
// Bytes shift MSB-first into per-register shadows; a commit copies every shadow out in one cycle.
module config_reg_slot #(
    parameter int word_width = 8,
    parameter int num_words  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr,
    input  logic                            commit,
    input  logic                            clr,
    input  logic [word_width-1:0]           data,
    output logic [num_words*word_width-1:0] shadow,
    output logic                            cnt_nz,
    output logic                            complete
);
    localparam int R     = num_words * word_width;
    localparam int CNT_W = (num_words > 1) ? $clog2(num_words) : 1;

    logic [CNT_W-1:0] cnt;
    logic [R-1:0]     shifted;
    logic             last;

    // Oldest byte falls off the top; a single-byte register just reloads.
    if (num_words == 1) begin : g_one
        assign shifted = data;
    end else begin : g_many
        assign shifted = {shadow[R-word_width-1:0], data};
    end

    assign last   = (cnt == CNT_W'(num_words - 1));
    assign cnt_nz = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shadow   <= '0;
            cnt      <= '0;
            complete <= 1'b0;
        end else if (wr) begin
            shadow <= shifted;
            cnt    <= last ? '0 : cnt + CNT_W'(1);
            if (last) complete <= 1'b1;
        end else if (commit) begin
            cnt      <= '0;
            complete <= 1'b0;
        end
    end
endmodule

module config_reg_bank #(
    parameter int word_width = 8,
    parameter int num_words  = 4,
    parameter int num_regs   = 4,
    parameter int addr_width = 16,
    parameter int base_addr  = 0
) (
    input  logic             clk,
    input  logic             rst,
    config_reg_bank_if.slave bus
);
    localparam int R = num_words * word_width;

    localparam logic [0:0] ST_ARMED = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [31:0]                   gpio_q;
    logic                          sample_vld;
    logic [0:0]                    state;
    logic [addr_width-1:0]         addr_q;
    logic [word_width-1:0]         data_q;
    logic                          w_clk_q;
    logic                          fire;
    logic                          commit_hit;
    logic                          clr_hit;
    logic [num_regs-1:0][R-1:0]    shadow;
    logic [num_regs-1:0][R-1:0]    reg_q;
    logic [num_regs-1:0]           cnt_nz;
    logic [num_regs-1:0]           complete;
    logic                          pulse_q;
    logic                          err_q;
    logic                          unused_bits;

    assign addr_q      = gpio_q[addr_width-1:0];
    assign data_q      = gpio_q[16 +: word_width];
    assign w_clk_q     = gpio_q[24];
    assign unused_bits = ^gpio_q[31:25];

    assign fire       = (state == ST_ARMED) && w_clk_q;
    assign commit_hit = fire && (addr_q == addr_width'(base_addr + num_regs));
    assign clr_hit    = fire && (addr_q == addr_width'(base_addr + num_regs + 1));

    // gpio_q holds its reset value, not a real bus sample, in the first cycle
    // after reset; sample_vld keeps HOLD from re-arming on that fake low.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_q     <= '0;
            sample_vld <= 1'b0;
            state      <= ST_HOLD;
        end else begin
            gpio_q     <= bus.gpio_in;
            sample_vld <= 1'b1;
            case (state)
                ST_ARMED: if (w_clk_q) state <= ST_HOLD;
                default:  if (sample_vld && !w_clk_q) state <= ST_ARMED;
            endcase
        end
    end

    for (genvar k = 0; k < num_regs; k++) begin : g_reg
        logic wr;
        assign wr = fire && (addr_q == addr_width'(base_addr + k));

        config_reg_slot #(
            .word_width (word_width),
            .num_words  (num_words)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .wr       (wr),
            .commit   (commit_hit),
            .clr      (clr_hit),
            .data     (data_q),
            .shadow   (shadow[k]),
            .cnt_nz   (cnt_nz[k]),
            .complete (complete[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q   <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pulse_q <= commit_hit;
            if (commit_hit) begin
                reg_q <= shadow;
                if (|cnt_nz) err_q <= 1'b1;
            end else if (clr_hit) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.reg_out      = reg_q;
    assign bus.reg_complete = complete;
    assign bus.commit_pulse = pulse_q;
    assign bus.err_partial  = err_q;
endmodule

// File: tb/tb_config_reg_bank.sv
// Randomized and directed bench for config_reg_bank against a byte-count reference model.
module tb_config_reg_bank;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    config_reg_bank_if #(.word_width(8), .num_words(4), .num_regs(4)) bus ();

    config_reg_bank #(
        .word_width (8),
        .num_words  (4),
        .num_regs   (4),
        .addr_width (16),
        .base_addr  (16'h0010)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference: per-register byte count since last commit/clear decides completeness and errors.
    logic [31:0] m_shadow [4];
    logic [31:0] m_out    [4];
    int          m_nb     [4];
    bit          m_err;
    int          exp_pulses = 0;
    int          pulses     = 0;
    int          b2b        = 0;
    bit          prev_pulse = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.commit_pulse) pulses++;
            if (bus.commit_pulse && prev_pulse) b2b++;
            prev_pulse = bus.commit_pulse;
        end else begin
            prev_pulse = 0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int k = 0; k < 4; k++) begin
            m_shadow[k] = '0;
            m_out[k]    = '0;
            m_nb[k]     = 0;
        end
        m_err = 0;
    endfunction

    function automatic void m_apply(input logic [15:0] a, input logic [7:0] d);
        if (a >= 16'h0010 && a < 16'h0014) begin
            int k = int'(a - 16'h0010);
            m_shadow[k] = {m_shadow[k][23:0], d};
            m_nb[k]++;
        end else if (a == 16'h0014) begin
            for (int k = 0; k < 4; k++) begin
                if (m_nb[k] % 4 != 0) m_err = 1;
                m_out[k] = m_shadow[k];
                m_nb[k]  = 0;
            end
            exp_pulses++;
        end else if (a == 16'h0015) begin
            for (int k = 0; k < 4; k++) begin
                m_shadow[k] = '0;
                m_nb[k]     = 0;
            end
            m_err = 0;
        end
    endfunction

    task automatic check_state(input string tag);
        logic [127:0] e_out;
        logic [3:0]   e_cmp;
        #1;
        for (int k = 0; k < 4; k++) begin
            e_out[k*32 +: 32] = m_out[k];
            e_cmp[k]          = (m_nb[k] >= 4);
        end
        chk({tag, "_out"},    bus.reg_out,      e_out);
        chk({tag, "_cmp"},    bus.reg_complete, 128'(e_cmp));
        chk({tag, "_err"},    bus.err_partial,  128'(m_err));
        chk({tag, "_pulses"}, pulses,           exp_pulses);
    endtask

    // One w_clk pulse: addr/data set a cycle before w_clk rises, held hold cycles, low low cycles.
    task automatic cmd(input logic [15:0] a, input logic [7:0] d, input int hold, input int low);
        @(negedge clk) bus.gpio_in = {7'b0, 1'b0, d, a};
        @(negedge clk) bus.gpio_in[24] = 1'b1;
        repeat (hold) @(negedge clk);
        bus.gpio_in[24] = 1'b0;
        repeat (low) @(negedge clk);
        m_apply(a, d);
    endtask

    initial begin
        logic [7:0] seq [4];
        bus.gpio_in = '0;
        rst = 1'b1;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_state("reset");
        chk("reset_pulse", bus.commit_pulse, 0);

        // Single register load then commit.
        seq[0] = 8'hDE; seq[1] = 8'hAD; seq[2] = 8'hBE; seq[3] = 8'hEF;
        for (int i = 0; i < 4; i++) cmd(16'h0012, seq[i], 1, 2);
        check_state("load2_pre");
        chk("load2_cmp", bus.reg_complete, 4'b0100);
        cmd(16'h0014, 8'h00, 1, 2);
        check_state("load2_commit");
        chk("load2_val", bus.reg_out[64 +: 32], 32'hDEADBEEF);

        // Long w_clk high executes once.
        cmd(16'h0011, 8'h5A, 20, 2);
        check_state("long_hold");
        cmd(16'h0014, 8'h00, 1, 2);
        check_state("long_commit");
        chk("long_val", bus.reg_out[32 +: 32], 32'h0000005A);
        chk("long_err", bus.err_partial, 1);

        // Overflow keeps shifting.
        for (int i = 1; i <= 6; i++) cmd(16'h0010, 8'(i), 1, 2);
        cmd(16'h0014, 8'h00, 1, 2);
        check_state("ovf");
        chk("ovf_val", bus.reg_out[0 +: 32], 32'h03040506);

        // Clear leaves outputs alone; unmapped address is ignored.
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        for (int i = 0; i < 4; i++) cmd(16'h0013, seq[i], 1, 2);
        cmd(16'h0014, 8'h00, 1, 2);
        cmd(16'h0013, 8'hAA, 1, 2);
        cmd(16'h0013, 8'hBB, 2, 2);
        cmd(16'h0015, 8'h00, 1, 2);
        cmd(16'h00FF, 8'hCC, 1, 2);
        check_state("clear");
        chk("clear_val", bus.reg_out[96 +: 32], 32'h11223344);
        chk("clear_err", bus.err_partial, 0);
        cmd(16'h0014, 8'h00, 1, 2);
        check_state("clear_shadow0");

        // Reset mid-sequence with w_clk held high across release.
        cmd(16'h0012, 8'h01, 1, 2);
        cmd(16'h0012, 8'h02, 1, 2);
        @(negedge clk) bus.gpio_in = {7'b0, 1'b1, 8'h77, 16'h0012};
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        bus.gpio_in[24] = 1'b0;
        repeat (2) @(negedge clk);
        check_state("rst_mid");
        seq[0] = 8'hCA; seq[1] = 8'hFE; seq[2] = 8'hF0; seq[3] = 8'h0D;
        for (int i = 0; i < 4; i++) cmd(16'h0012, seq[i], 1, 2);
        cmd(16'h0014, 8'h00, 1, 2);
        check_state("rst_recover");
        chk("rst_val", bus.reg_out[64 +: 32], 32'hCAFEF00D);

        // Random command stream.
        for (int n = 0; n < 150; n++) begin
            int          r = int'($urandom_range(0, 9));
            logic [15:0] a;
            if (r < 6)       a = 16'h0010 + 16'(r % 4);
            else if (r < 8)  a = 16'h0014;
            else if (r == 8) a = 16'h0015;
            else begin
                a = 16'($urandom);
                if (a >= 16'h0010 && a <= 16'h0015) a = 16'h00FF;
            end
            cmd(a, 8'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(2, 3)));
            check_state("rand");
        end

        chk("no_back2back", b2b, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
